serial_subtractor: RTL

- Bit-serial multi-bit subtractor: computes d = a - b - bin over WIDTH clock cycles.
- Reuses one 1-bit full-subtractor cell, LSB first, with the borrow fed back through a register.
- Sits directly downstream of the operand source and upstream of result consumers.
- Uses valid/ready handshakes on both sides; trades throughput for area versus a ripple array.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_fs_cell.sv | 13 +
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic borrow_o
);

    assign d_o      = a_i ^ b_i ^ bin_i;
    assign borrow_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one fs_cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one bit per cycle through fs_cell, WIDTH cycles
// DONE  | result presented, out_valid=1, waits for out_ready
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range 2..64");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  d_sh_q, d_sh_d;
    logic              brw_q, brw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  d_res_q, d_res_d;
    logic              bo_res_q, bo_res_d;
    logic              cell_d, cell_b;
    logic [WIDTH-1:0]  d_shifted;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    fs_cell u_cell (
        .a_i      (a_sh_q[0]),
        .b_i      (b_sh_q[0]),
        .bin_i    (brw_q),
        .d_o      (cell_d),
        .borrow_o (cell_b)
    );

    assign d_shifted = {cell_d, d_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        d_res_d  = d_res_q;
        bo_res_d = bo_res_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = d_shifted;
                brw_d  = cell_b;
                cnt_d  = cnt_q + CW'(1);
                // Result registers update only on completion so d/borrow hold the
                // previous result while a new operation is in flight.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    d_res_d  = d_shifted;
                    bo_res_d = cell_b;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            d_res_q  <= '0;
            bo_res_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            d_res_q  <= d_res_d;
            bo_res_q <= bo_res_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // rst_n gating keeps in_ready low while reset is held even though state reads IDLE.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign d         = d_res_q;
    assign borrow    = bo_res_q;

endmodule
